// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter.
//  XLEN, ROB_TAG_LEN : datapath and ROB tag widths
//  BUS_COMMAND       : command driven on the Dmem port
//  MEM_SIZE          : access size for the Dmem port
//  ARB_STATE         : arbiter FSM state encoding (also exported for debug)
package dmem_port_arbiter_pkg;

  localparam int XLEN        = 32;
  localparam int ROB_TAG_LEN = 5;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic [1:0] {
    BYTE   = 2'h0,
    HALF   = 2'h1,
    WORD   = 2'h2,
    DOUBLE = 2'h3
  } MEM_SIZE;

  typedef enum logic [1:0] {
    IDLE       = 2'h0,
    LOAD_BUSY  = 2'h1,
    STORE_BUSY = 2'h2
  } ARB_STATE;

endpackage

// File: rtl/dmem_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker for the load buffers.
//  req         : per-requester request bits
//  ptr         : index that has highest priority this round
//  grant       : one-hot winner (all zero when nothing requests)
//  grant_idx   : binary index of the winner
//  grant_valid : at least one request present
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  // Scan starting at ptr and wrapping; the first requester seen wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_valid && req[(int'(ptr) + k) % NUM_REQ]) begin
        grant_valid                          = 1'b1;
        grant_idx                            = IDX_W'((int'(ptr) + k) % NUM_REQ);
        grant[(int'(ptr) + k) % NUM_REQ]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between NUM_LB load buffers and the
// ROB store-commit path. Stores win over loads; loads are round-robin.
// Optional watchdog: define DMEM_ARB_TIMEOUT_EN to abort a transaction that
// sees no Dmem_ready within TIMEOUT_CYCLES busy cycles.
//
// Ports
//  clock, reset          : clock, asynchronous active-low reset
//  lb_read_mem/address/rob_tag : per-load-buffer request, address, ROB tag
//  st_commit_req/address/data/size : store at the ROB head
//  branch_misprediction  : squash the in-flight load result
//  Dmem_ready/Dmem_rdata : memory completion and load data
//  dmem_command/addr/wdata/size : command to mem_stage
//  lb_grant              : one-hot, held while the load is outstanding
//  lb_done/load_result/load_rob_tag : one-cycle load completion
//  st_commit_ack         : one-cycle store completion
//  arb_busy, timeout_err : status
//  state_dbg             : current FSM state
//
// Handshake: a request is a level held by the requester; the arbiter samples
// it only in IDLE and captures address/data/tag on that edge, so the requester
// may drop or change its inputs afterwards. The transaction is outstanding
// from the next cycle until the cycle in which Dmem_ready is high; the done or
// ack pulse follows on the cycle after that, which is always an IDLE cycle.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int NUM_LB         = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_LB-1:0]             lb_read_mem,
  input  logic [NUM_LB*XLEN-1:0]        lb_address,
  input  logic [NUM_LB*ROB_TAG_LEN-1:0] lb_rob_tag,
  input  logic                          st_commit_req,
  input  logic [XLEN-1:0]               st_address,
  input  logic [XLEN-1:0]               st_data,
  input  MEM_SIZE                       st_size,
  input  logic                          branch_misprediction,
  input  logic                          Dmem_ready,
  input  logic [XLEN-1:0]               Dmem_rdata,
  output BUS_COMMAND                    dmem_command,
  output logic [XLEN-1:0]               dmem_addr,
  output logic [XLEN-1:0]               dmem_wdata,
  output MEM_SIZE                       dmem_size,
  output logic [NUM_LB-1:0]             lb_grant,
  output logic [NUM_LB-1:0]             lb_done,
  output logic [XLEN-1:0]               load_result,
  output logic [ROB_TAG_LEN-1:0]        load_rob_tag,
  output logic                          st_commit_ack,
  output logic                          arb_busy,
  output logic                          timeout_err,
  output ARB_STATE                      state_dbg
);

  localparam int IDX_W = (NUM_LB > 1) ? $clog2(NUM_LB) : 1;

  ARB_STATE               state, next_state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       win_idx;
  logic [XLEN-1:0]        cap_addr;
  logic [XLEN-1:0]        cap_data;
  MEM_SIZE                cap_size;
  logic [ROB_TAG_LEN-1:0] cap_tag;
  logic                   squash;

  logic                   take;
  logic                   take_store;
  logic                   timeout_hit;
  logic                   wd_expired;
  logic [NUM_LB-1:0]      done_next;
  logic                   ack_next;

  logic [NUM_LB-1:0]      arb_grant;
  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_any;

  rr_arbiter #(
    .NUM_REQ (NUM_LB),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req         (lb_read_mem),
    .ptr         (rr_ptr),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_any)
  );

  assign state_dbg = state;
  assign arb_busy  = (state != IDLE);

  // Next state, capture strobes and Dmem-side outputs.
  always_comb begin
    next_state   = state;
    take         = 1'b0;
    take_store   = 1'b0;
    timeout_hit  = 1'b0;
    dmem_command = BUS_NONE;
    case (state)
      IDLE: begin
        if (st_commit_req) begin
          next_state = STORE_BUSY;
          take       = 1'b1;
          take_store = 1'b1;
        end else if (arb_any) begin
          next_state = LOAD_BUSY;
          take       = 1'b1;
        end
      end
      LOAD_BUSY: begin
        dmem_command = BUS_LOAD;
        if (Dmem_ready) begin
          next_state = IDLE;
        end else if (wd_expired) begin
          next_state  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      STORE_BUSY: begin
        dmem_command = BUS_STORE;
        if (Dmem_ready) begin
          next_state = IDLE;
        end else if (wd_expired) begin
          next_state  = IDLE;
          timeout_hit = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Per-requester outputs and completion pulses for the next cycle.
  always_comb begin
    lb_grant   = '0;
    done_next  = '0;
    ack_next   = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_size  = BYTE;
    if (state != IDLE) begin
      dmem_addr  = cap_addr;
      dmem_wdata = cap_data;
      dmem_size  = cap_size;
    end
    if (state == LOAD_BUSY) begin
      lb_grant[win_idx] = 1'b1;
      // A mispredict coincident with Dmem_ready squashes as well.
      if (Dmem_ready && !squash && !branch_misprediction) begin
        done_next[win_idx] = 1'b1;
      end
    end
    if (state == STORE_BUSY && Dmem_ready) begin
      ack_next = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      win_idx       <= '0;
      cap_addr      <= '0;
      cap_data      <= '0;
      cap_size      <= BYTE;
      cap_tag       <= '0;
      squash        <= 1'b0;
      lb_done       <= '0;
      load_result   <= '0;
      load_rob_tag  <= '0;
      st_commit_ack <= 1'b0;
    end else begin
      state         <= next_state;
      lb_done       <= done_next;
      st_commit_ack <= ack_next;
      load_result   <= (done_next != '0) ? Dmem_rdata : '0;
      load_rob_tag  <= (done_next != '0) ? cap_tag : '0;
      if (take) begin
        squash <= 1'b0;
        if (take_store) begin
          cap_addr <= st_address;
          cap_data <= st_data;
          cap_size <= st_size;
        end else begin
          cap_addr <= lb_address[int'(arb_idx)*XLEN +: XLEN];
          cap_data <= '0;
          cap_size <= WORD;
          cap_tag  <= lb_rob_tag[int'(arb_idx)*ROB_TAG_LEN +: ROB_TAG_LEN];
          win_idx  <= arb_idx;
          // The pointer only moves on load grants; stores do not disturb fairness.
          rr_ptr   <= (arb_idx == IDX_W'(NUM_LB - 1)) ? '0 : arb_idx + IDX_W'(1);
        end
      end else if (state == LOAD_BUSY && branch_misprediction) begin
        squash <= 1'b1;
      end
    end
  end

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] busy_cnt;
  logic             timeout_q;

  // busy_cnt counts completed busy cycles of the current transaction.
  assign wd_expired  = (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == IDLE) busy_cnt <= '0;
      else               busy_cnt <= busy_cnt + CNT_W'(1);
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end
`else
  assign wd_expired  = 1'b0;
  // Constant low; the parameter is referenced only to keep it in use.
  assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int TO = 8;

  logic                     clock;
  logic                     reset;
  logic [N-1:0]             lb_read_mem;
  logic [N*XLEN-1:0]        lb_address;
  logic [N*ROB_TAG_LEN-1:0] lb_rob_tag;
  logic                     st_commit_req;
  logic [XLEN-1:0]          st_address;
  logic [XLEN-1:0]          st_data;
  MEM_SIZE                  st_size;
  logic                     branch_misprediction;
  logic                     Dmem_ready;
  logic [XLEN-1:0]          Dmem_rdata;
  BUS_COMMAND               dmem_command;
  logic [XLEN-1:0]          dmem_addr;
  logic [XLEN-1:0]          dmem_wdata;
  MEM_SIZE                  dmem_size;
  logic [N-1:0]             lb_grant;
  logic [N-1:0]             lb_done;
  logic [XLEN-1:0]          load_result;
  logic [ROB_TAG_LEN-1:0]   load_rob_tag;
  logic                     st_commit_ack;
  logic                     arb_busy;
  logic                     timeout_err;
  ARB_STATE                 state_dbg;

  int vectors = 0;
  int errors  = 0;
  int model_rr = 0;

  dmem_port_arbiter #(.NUM_LB(N), .TIMEOUT_CYCLES(TO)) dut (
    .clock                (clock),
    .reset                (reset),
    .lb_read_mem          (lb_read_mem),
    .lb_address           (lb_address),
    .lb_rob_tag           (lb_rob_tag),
    .st_commit_req        (st_commit_req),
    .st_address           (st_address),
    .st_data              (st_data),
    .st_size              (st_size),
    .branch_misprediction (branch_misprediction),
    .Dmem_ready           (Dmem_ready),
    .Dmem_rdata           (Dmem_rdata),
    .dmem_command         (dmem_command),
    .dmem_addr            (dmem_addr),
    .dmem_wdata           (dmem_wdata),
    .dmem_size            (dmem_size),
    .lb_grant             (lb_grant),
    .lb_done              (lb_done),
    .load_result          (load_result),
    .load_rob_tag         (load_rob_tag),
    .st_commit_ack        (st_commit_ack),
    .arb_busy             (arb_busy),
    .timeout_err          (timeout_err),
    .state_dbg            (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "simulation time limit");
  end

  // ---------------- checking ----------------
  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_value({tag, "_cmd"},   dmem_command, BUS_NONE);
    check_value({tag, "_grant"}, lb_grant, '0);
    check_value({tag, "_busy"},  arb_busy, 1'b0);
    check_value({tag, "_state"}, state_dbg, IDLE);
  endtask

  // ---------------- reference model ----------------
  // Store first; otherwise first requesting LB scanning upward from model_rr.
  task automatic predict(output int win, output logic is_store);
    win = -1;
    is_store = st_commit_req;
    if (!is_store) begin
      for (int k = 0; k < N; k++) begin
        if (win < 0 && lb_read_mem[(model_rr + k) % N]) win = (model_rr + k) % N;
      end
      if (win >= 0) model_rr = (win + 1) % N;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic new_requests();
    for (int i = 0; i < N; i++) begin
      if (!lb_read_mem[i] && $urandom_range(0, 1) == 1) begin
        lb_read_mem[i] = 1'b1;
        lb_address[i*XLEN +: XLEN] = $urandom;
        lb_rob_tag[i*ROB_TAG_LEN +: ROB_TAG_LEN] = ROB_TAG_LEN'($urandom);
      end
    end
    if (!st_commit_req && $urandom_range(0, 3) == 0) begin
      st_commit_req = 1'b1;
      st_address    = $urandom;
      st_data       = $urandom;
      st_size       = MEM_SIZE'($urandom_range(0, 2));
    end
  endtask

  // Called at a negedge while the DUT is idle and something requests.
  // Returns at the negedge of the first busy cycle, with the winner's
  // request dropped and its inputs scrambled.
  task automatic start_txn(output int win, output logic is_store,
                           output logic [ROB_TAG_LEN-1:0] exp_tag);
    logic [XLEN-1:0] exp_addr;
    logic [XLEN-1:0] exp_wdata;
    MEM_SIZE         exp_size;
    logic [N-1:0]    exp_grant;
    predict(win, is_store);
    exp_grant = '0;
    exp_tag   = '0;
    if (is_store) begin
      exp_addr  = st_address;
      exp_wdata = st_data;
      exp_size  = st_size;
    end else begin
      exp_addr  = lb_address[win*XLEN +: XLEN];
      exp_wdata = '0;
      exp_size  = WORD;
      exp_tag   = lb_rob_tag[win*ROB_TAG_LEN +: ROB_TAG_LEN];
      exp_grant[win] = 1'b1;
    end
    @(negedge clock);
    check_value("cmd", dmem_command, is_store ? BUS_STORE : BUS_LOAD);
    check_value("addr", dmem_addr, exp_addr);
    check_value("wdata", dmem_wdata, exp_wdata);
    check_value("size", dmem_size, exp_size);
    check_value("grant", lb_grant, exp_grant);
    check_value("busy", arb_busy, 1'b1);
    if (is_store) begin
      st_commit_req = 1'b0;
      st_address    = $urandom;
      st_data       = $urandom;
    end else begin
      lb_read_mem[win] = 1'b0;
      lb_address[win*XLEN +: XLEN] = $urandom;
      lb_rob_tag[win*ROB_TAG_LEN +: ROB_TAG_LEN] = ROB_TAG_LEN'($urandom);
    end
  endtask

  // lat: busy cycles before the one carrying Dmem_ready.
  // misp_at: busy-cycle index carrying branch_misprediction (-1 none).
  task automatic run_txn(input int lat, input int misp_at, input logic [XLEN-1:0] rdata);
    int win;
    logic is_store;
    logic squashed;
    logic [ROB_TAG_LEN-1:0] tag;
    logic [N-1:0] exp_done;
    start_txn(win, is_store, tag);
    squashed = 1'b0;
    for (int c = 0; c <= lat; c++) begin
      Dmem_ready = (c == lat);
      Dmem_rdata = (c == lat) ? rdata : $urandom;
      branch_misprediction = (c == misp_at);
      if (c == misp_at && !is_store) squashed = 1'b1;
      @(negedge clock);
      if (c < lat) begin
        check_value("hold_cmd", dmem_command, is_store ? BUS_STORE : BUS_LOAD);
        check_value("hold_done", lb_done, '0);
      end
    end
    Dmem_ready = 1'b0;
    branch_misprediction = 1'b0;
    exp_done = '0;
    if (!is_store && !squashed) exp_done[win] = 1'b1;
    check_value("lb_done", lb_done, exp_done);
    check_value("st_ack", st_commit_ack, is_store);
    if (exp_done != '0) begin
      check_value("load_result", load_result, rdata);
      check_value("load_tag", load_rob_tag, tag);
    end
    check_idle_outputs("after_txn");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int win;
    logic is_store;
    logic [ROB_TAG_LEN-1:0] tag;
    logic [N-1:0] exp_done;

    reset = 1'b0;
    lb_read_mem = '0;
    lb_address = '0;
    lb_rob_tag = '0;
    st_commit_req = 1'b0;
    st_address = '0;
    st_data = '0;
    st_size = BYTE;
    branch_misprediction = 1'b0;
    Dmem_ready = 1'b0;
    Dmem_rdata = '0;
    repeat (2) @(negedge clock);
    check_idle_outputs("reset");
    check_value("reset_done", lb_done, '0);
    check_value("reset_ack", st_commit_ack, 1'b0);
    check_value("reset_to", timeout_err, 1'b0);
    reset = 1'b1;
    model_rr = 0;
    @(negedge clock);

    // Two loads at once: LB0 then LB1.
    lb_read_mem = 2'b11;
    lb_address[0 +: XLEN] = 32'h0000_1000;
    lb_address[XLEN +: XLEN] = 32'h0000_2000;
    lb_rob_tag = {5'd7, 5'd3};
    run_txn(2, -1, 32'hDEADBEEF);
    run_txn(0, -1, 32'h1234_5678);

    // Store beats a simultaneous load.
    st_commit_req = 1'b1;
    st_address = 32'h100;
    st_data = 32'h55;
    st_size = HALF;
    lb_read_mem = 2'b01;
    lb_address[0 +: XLEN] = 32'h0000_0300;
    run_txn(1, -1, 32'h0);
    run_txn(1, -1, 32'hCAFE_F00D);

    // Mispredict one cycle after the grant, then another load is served.
    lb_read_mem = 2'b01;
    run_txn(3, 1, 32'hAAAA_5555);
    lb_read_mem = 2'b10;
    run_txn(0, -1, 32'h0BAD_CAFE);

    // Mispredict coincident with Dmem_ready.
    lb_read_mem = 2'b01;
    run_txn(2, 2, 32'h1111_2222);

    // Dmem_ready while idle is ignored.
    Dmem_ready = 1'b1;
    @(negedge clock);
    Dmem_ready = 1'b0;
    @(negedge clock);
    check_value("idle_ready_done", lb_done, '0);
    check_value("idle_ready_ack", st_commit_ack, 1'b0);
    check_idle_outputs("idle_ready");

    // Randomized traffic.
    for (int it = 0; it < 80; it++) begin
      new_requests();
      if (st_commit_req || lb_read_mem != '0) begin
        int lat;
        int m;
        lat = $urandom_range(0, 3);
        m = $urandom_range(0, 6);
        run_txn(lat, (m <= lat) ? m : -1, $urandom);
      end else begin
        @(negedge clock);
        check_idle_outputs("rand_idle");
      end
    end
    // Drain outstanding requests.
    while (st_commit_req || lb_read_mem != '0) run_txn(0, -1, $urandom);

    // Memory that never answers.
    lb_read_mem = 2'b01;
    lb_address[0 +: XLEN] = 32'h0000_0444;
    start_txn(win, is_store, tag);
    repeat (TO - 1) @(negedge clock);
    check_value("wd_busy_before", state_dbg, LOAD_BUSY);
    @(negedge clock);
`ifdef DMEM_ARB_TIMEOUT_EN
    check_value("wd_state", state_dbg, IDLE);
    check_value("wd_err", timeout_err, 1'b1);
    check_value("wd_done", lb_done, '0);
    @(negedge clock);
    check_value("wd_done_late", lb_done, '0);
    check_value("wd_err_sticky", timeout_err, 1'b1);
`else
    check_value("wd_state", state_dbg, LOAD_BUSY);
    check_value("wd_err", timeout_err, 1'b0);
    repeat (4) @(negedge clock);
    check_value("wd_still_busy", state_dbg, LOAD_BUSY);
    Dmem_ready = 1'b1;
    Dmem_rdata = 32'h7777_0000;
    @(negedge clock);
    Dmem_ready = 1'b0;
    exp_done = '0;
    exp_done[win] = 1'b1;
    check_value("wd_late_done", lb_done, exp_done);
    check_value("wd_late_result", load_result, 32'h7777_0000);
`endif

    // Reset in the middle of a load aborts it.
    @(negedge clock);
    lb_read_mem = 2'b10;
    lb_address[XLEN +: XLEN] = 32'h0000_0888;
    start_txn(win, is_store, tag);
    reset = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    check_value("mid_reset_addr", dmem_addr, '0);
    check_value("mid_reset_to", timeout_err, 1'b0);
    lb_read_mem = '0;
    Dmem_ready = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    Dmem_ready = 1'b0;
    model_rr = 0;
    @(negedge clock);
    check_value("post_reset_done", lb_done, '0);
    check_value("post_reset_ack", st_commit_ack, 1'b0);
    check_idle_outputs("post_reset");

    // Round-robin pointer restarts at LB0.
    lb_read_mem = 2'b11;
    run_txn(0, -1, 32'h0F0F_0F0F);
    run_txn(1, -1, 32'hF0F0_F0F0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
